// File: rtl/mat_result_serializer.sv
// -----------------------------------------------------------------------------
// mat_result_serializer
//
// Drain stage behind the pipelined SIMD matrix multiplier. A complete N x N
// result matrix is captured into a holding buffer. It is then streamed out one
// element per beat, tagged with its row/column and a last-element flag. While
// a matrix is still draining, cen_out is held low so the multiplier pipeline
// freezes. A frozen multiplier keeps presenting its finished matrix until this
// block is ready to take it.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   valid_in   multiplier valid_out
//   result_in  multiplier result matrix, [row][col]
//   cen_out    multiplier clock enable (1 = pipeline may advance)
//   m_data     current element
//   m_valid    m_data is valid
//   m_ready    downstream accepts the beat
//   m_row      row index of m_data
//   m_col      column index of m_data
//   m_last     final element of the matrix
//   mat_count  matrices fully emitted, wraps modulo 2^CW
//
// Handshake semantics:
//   Output beat : transfers on a rising edge where m_valid && m_ready. Once
//                 m_valid is high, it stays high and m_data/m_row/m_col/m_last
//                 hold stable until the beat transfers.
//   Capture     : transfers on a rising edge where valid_in && cen_out.
//                 valid_in seen while cen_out is low is ignored. The frozen
//                 multiplier re-presents the same matrix later.
// -----------------------------------------------------------------------------
module mat_result_serializer #(
    parameter int W_OUT     = 32,
    parameter int N         = 2,
    parameter int COL_MAJOR = 0,
    parameter int CW        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [W_OUT-1:0] result_in [N][N],
    output logic                    cen_out,
    output logic signed [W_OUT-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(N)-1:0]    m_row,
    output logic [$clog2(N)-1:0]    m_col,
    output logic                    m_last,
    output logic [CW-1:0]           mat_count
);

    localparam int             RW      = $clog2(N);
    localparam logic [RW-1:0]  IDX_MAX = RW'(N - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]              state_q;
    logic signed [W_OUT-1:0] mat_q [N][N];
    logic [RW-1:0]           row_q;
    logic [RW-1:0]           col_q;
    logic [RW-1:0]           row_d;
    logic [RW-1:0]           col_d;
    logic [CW-1:0]           count_q;
    logic                    beat;
    logic                    capture;

    // Output view of the buffer at the current index.
    assign m_valid   = (state_q == S_DRAIN);
    assign m_row     = row_q;
    assign m_col     = col_q;
    assign m_data    = mat_q[row_q][col_q];
    assign m_last    = (row_q == IDX_MAX) && (col_q == IDX_MAX);
    assign mat_count = count_q;

    // The multiplier may only advance when the buffer is free: either it is
    // empty, or the last element is leaving on this very edge. The second
    // case is what allows back-to-back matrices with no bubble.
    assign cen_out = (state_q == S_IDLE) || (m_last && m_ready);

    assign beat    = m_valid && m_ready;
    assign capture = valid_in && cen_out;

    // Next element index for a non-last beat. The fast-moving coordinate
    // wraps and carries into the slow one.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (COL_MAJOR != 0) begin
            if (row_q == IDX_MAX) begin
                row_d = '0;
                col_d = col_q + RW'(1);
            end else begin
                row_d = row_q + RW'(1);
            end
        end else begin
            if (col_q == IDX_MAX) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + RW'(1);
            end
        end
    end

    // Control: state, element index and completed-matrix counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        state_q <= S_DRAIN;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (beat) begin
                        if (m_last) begin
                            count_q <= count_q + CW'(1);
                            // The index returns to (0,0) whether a new
                            // matrix arrives or not. An idle block therefore
                            // shows m_last = 0.
                            row_q   <= '0;
                            col_q   <= '0;
                            if (!capture) begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            row_q <= row_d;
                            col_q <= col_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    row_q   <= '0;
                    col_q   <= '0;
                end
            endcase
        end
    end

    // Holding buffer. It is only written on a capture, and a capture can
    // only occur when the buffer is empty or its last element is leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
        end else if (capture) begin
            mat_q <= result_in;
        end
    end

endmodule

// File: tb/tb_mat_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_mat_result_serializer
//
// Bench for mat_result_serializer with N = 2. The row-major instance uses the
// default CW. A column-major instance uses CW = 2, so that mat_count wrap can
// be reached quickly. Inputs change on the falling edge, and outputs are
// sampled 1 ns later, which is well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mat_result_serializer;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int CW = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                valid_in;
  logic                m_ready;
  logic signed [W-1:0] result_in [N][N];

  logic                cen_out;
  logic signed [W-1:0] m_data;
  logic                m_valid;
  logic [0:0]          m_row;
  logic [0:0]          m_col;
  logic                m_last;
  logic [CW-1:0]       mat_count;

  logic                c_cen_out;
  logic signed [W-1:0] c_m_data;
  logic                c_m_valid;
  logic [0:0]          c_m_row;
  logic [0:0]          c_m_col;
  logic                c_m_last;
  logic [1:0]          c_mat_count;

  mat_result_serializer #(.W_OUT(W), .N(N), .COL_MAJOR(0), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .result_in (result_in),
    .cen_out   (cen_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .mat_count (mat_count)
  );

  mat_result_serializer #(.W_OUT(W), .N(N), .COL_MAJOR(1), .CW(2)) dut_cm (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .result_in (result_in),
    .cen_out   (c_cen_out),
    .m_data    (c_m_data),
    .m_valid   (c_m_valid),
    .m_ready   (m_ready),
    .m_row     (c_m_row),
    .m_col     (c_m_col),
    .m_last    (c_m_last),
    .mat_count (c_mat_count)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // sel 0: [[19,22],[43,50]]   sel 1: [[-1,2],[3,-4]]
  task automatic set_mat(input logic sel);
    if (sel) begin
      result_in[0][0] = -1; result_in[0][1] = 2;
      result_in[1][0] = 3;  result_in[1][1] = -4;
    end else begin
      result_in[0][0] = 19; result_in[0][1] = 22;
      result_in[1][0] = 43; result_in[1][1] = 50;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    m_ready  = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  // One record per cycle: inputs driven for that cycle and the outputs
  // expected during it. m_data is only compared when ev (m_valid) is 1.
  typedef struct {
    logic vi;
    logic rdy;
    logic sel;
    logic ev;
    logic ecen;
    logic [W-1:0] edata;
    logic er;
    logic ec;
    logic el;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic vi, input logic rdy, input logic sel,
                              input logic ev, input logic ecen, input int edata,
                              input logic er, input logic ec, input logic el,
                              input int ecnt);
    vec_t v;
    v.vi = vi; v.rdy = rdy; v.sel = sel;
    v.ev = ev; v.ecen = ecen; v.edata = W'(edata);
    v.er = er; v.ec = ec; v.el = el; v.ecnt = CW'(ecnt);
    return v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------- test
  initial begin : main
    int beats;
    int done;
    int pos;
    logic [W-1:0] e;
    logic [0:0] cm_row [4];
    logic [0:0] cm_col [4];

    cm_row[0] = 1'b0; cm_row[1] = 1'b1; cm_row[2] = 1'b0; cm_row[3] = 1'b1;
    cm_col[0] = 1'b0; cm_col[1] = 1'b0; cm_col[2] = 1'b1; cm_col[3] = 1'b1;

    // Basic drain, ready always high.
    vec.push_back(mk(1,1,0, 0,1, 0, 0,0,0, 0));
    vec.push_back(mk(0,1,0, 1,0,19, 0,0,0, 0));
    vec.push_back(mk(0,1,0, 1,0,22, 0,1,0, 0));
    vec.push_back(mk(0,1,0, 1,0,43, 1,0,0, 0));
    vec.push_back(mk(0,1,0, 1,1,50, 1,1,1, 0));
    vec.push_back(mk(0,1,0, 0,1, 0, 0,0,0, 1));
    // Back-pressure 1,0,0,1,1,0,1. valid_in during the stalled last beat
    // (cen_out low) must be ignored.
    vec.push_back(mk(1,1,0, 0,1, 0, 0,0,0, 1));
    vec.push_back(mk(0,1,0, 1,0,19, 0,0,0, 1));
    vec.push_back(mk(0,0,0, 1,0,22, 0,1,0, 1));
    vec.push_back(mk(0,0,0, 1,0,22, 0,1,0, 1));
    vec.push_back(mk(0,1,0, 1,0,22, 0,1,0, 1));
    vec.push_back(mk(0,1,0, 1,0,43, 1,0,0, 1));
    vec.push_back(mk(1,0,1, 1,0,50, 1,1,1, 1));
    vec.push_back(mk(0,1,0, 1,1,50, 1,1,1, 1));
    vec.push_back(mk(0,1,0, 0,1, 0, 0,0,0, 2));
    // Back-to-back: second matrix offered during drain, taken as 50 leaves.
    vec.push_back(mk(1,1,0, 0,1, 0, 0,0,0, 2));
    vec.push_back(mk(1,1,1, 1,0,19, 0,0,0, 2));
    vec.push_back(mk(1,1,1, 1,0,22, 0,1,0, 2));
    vec.push_back(mk(1,1,1, 1,0,43, 1,0,0, 2));
    vec.push_back(mk(1,1,1, 1,1,50, 1,1,1, 2));
    vec.push_back(mk(0,1,1, 1,0,-1, 0,0,0, 3));
    vec.push_back(mk(0,1,1, 1,0, 2, 0,1,0, 3));
    vec.push_back(mk(0,1,1, 1,0, 3, 1,0,0, 3));
    vec.push_back(mk(0,1,1, 1,1,-4, 1,1,1, 3));
    vec.push_back(mk(0,1,0, 0,1, 0, 0,0,0, 4));

    set_mat(1'b0);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    m_ready  = 1'b1;

    // Reset / idle.
    do_reset(3);
    #1;
    check("rst m_valid",   32'(m_valid),   32'd0);
    check("rst cen_out",   32'(cen_out),   32'd1);
    check("rst mat_count", 32'(mat_count), 32'd0);
    check("rst m_row",     32'(m_row),     32'd0);
    check("rst m_col",     32'(m_col),     32'd0);
    check("rst m_last",    32'(m_last),    32'd0);
    check("rst m_data",    32'(m_data),    32'd0);

    // Table-driven sequences.
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      valid_in = vec[i].vi;
      m_ready  = vec[i].rdy;
      set_mat(vec[i].sel);
      #1;
      check($sformatf("vec%0d m_valid", i),   32'(m_valid),   32'(vec[i].ev));
      check($sformatf("vec%0d cen_out", i),   32'(cen_out),   32'(vec[i].ecen));
      check($sformatf("vec%0d m_row", i),     32'(m_row),     32'(vec[i].er));
      check($sformatf("vec%0d m_col", i),     32'(m_col),     32'(vec[i].ec));
      check($sformatf("vec%0d m_last", i),    32'(m_last),    32'(vec[i].el));
      check($sformatf("vec%0d mat_count", i), 32'(mat_count), 32'(vec[i].ecnt));
      if (vec[i].ev) begin
        check($sformatf("vec%0d m_data", i),  32'(m_data),    vec[i].edata);
      end
    end

    // Reset mid-matrix.
    do_reset(1);
    @(negedge clk);
    valid_in = 1'b1; m_ready = 1'b1; set_mat(1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    #1 check("mid 1st beat", 32'(m_data), 32'd19);
    @(negedge clk);
    #1 check("mid 2nd beat", 32'(m_data), 32'd22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst m_valid",   32'(m_valid),   32'd0);
    check("mid rst cen_out",   32'(cen_out),   32'd1);
    check("mid rst mat_count", 32'(mat_count), 32'd0);
    check("mid rst m_row",     32'(m_row),     32'd0);
    check("mid rst m_col",     32'(m_col),     32'd0);
    check("mid rst m_last",    32'(m_last),    32'd0);
    check("mid rst m_data",    32'(m_data),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("post rst m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("restart m_valid", 32'(m_valid), 32'd1);
    check("restart m_data",  32'(m_data),  32'd19);
    check("restart m_row",   32'(m_row),   32'd0);
    check("restart m_col",   32'(m_col),   32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("restart mat_count", 32'(mat_count), 32'd1);
    check("restart idle",      32'(m_valid),   32'd0);

    // Column-major order plus mat_count wrap (CW = 2). There are four
    // matrices in total. valid_in is held until the fourth is captured.
    do_reset(1);
    set_mat(1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(W'(19));
      exp_q.push_back(W'(43));
      exp_q.push_back(W'(22));
      exp_q.push_back(W'(50));
    end
    beats = 0;
    done  = 0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      valid_in = (beats < 12);
      m_ready  = 1'b1;
      #1;
      check($sformatf("cm cyc%0d mat_count", cyc), 32'(c_mat_count), 32'(done % 4));
      if (c_m_valid && m_ready) begin
        pos = beats % 4;
        e = exp_q.pop_front();
        check($sformatf("cm beat%0d data", beats), 32'(c_m_data), e);
        check($sformatf("cm beat%0d row", beats),  32'(c_m_row),  32'(cm_row[pos]));
        check($sformatf("cm beat%0d col", beats),  32'(c_m_col),  32'(cm_col[pos]));
        check($sformatf("cm beat%0d last", beats), 32'(c_m_last), 32'(pos == 3));
        if (pos == 3) done++;
        beats++;
      end
    end
    check("cm all beats seen", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("cm wrap mat_count", 32'(c_mat_count), 32'd0);
    check("cm final idle",     32'(c_m_valid),   32'd0);
    check("cm final cen_out",  32'(c_cen_out),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
